// File: rtl/retire_trace_buf.sv
// retire_trace_buf
//
// Buffers retirement events from a CPU core in a registered FIFO, so that a
// slower consumer (trace port, checker, logger) can drain them. Each stored
// record carries a sequential instruction number (inum) plus every event field.
// A halt event moves the block into HALTED. New events are ignored after that.
// Once the halt record has been drained, the block enters DONE.
//
// Optional build macro:
//   RETIRE_TRACE_FILTER_EN - events that write neither a register nor memory
//                            and are not a halt (branches, NOPs) are counted
//                            in inst_count but are not stored. Such events
//                            never cause a drop.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ev_valid                  retirement event present this cycle
//   ev_pc/wdata/maddr/mdata   retired PC, reg write data, mem address, store data
//   ev_regwrite/memread/
//   ev_memwrite/halt          retired-instruction flags
//   ev_wreg                   destination register
//   out_valid/out_ready       drain handshake (pop on out_valid && out_ready)
//   out_inum, out_*           head record
//   inst_count                accepted event count
//   drop_count                dropped event count
//   overflow                  sticky, set when any event has been dropped
//   done                      the halt record has drained

module retire_trace_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_valid,
  input  logic [DATA_W-1:0] ev_pc,
  input  logic [DATA_W-1:0] ev_wdata,
  input  logic [DATA_W-1:0] ev_maddr,
  input  logic [DATA_W-1:0] ev_mdata,
  input  logic              ev_regwrite,
  input  logic              ev_memread,
  input  logic              ev_memwrite,
  input  logic              ev_halt,
  input  logic [2:0]        ev_wreg,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_inum,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_wdata,
  output logic [DATA_W-1:0] out_maddr,
  output logic [DATA_W-1:0] out_mdata,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_halt,
  output logic [2:0]        out_wreg,
  output logic [CNT_W-1:0]  inst_count,
  output logic [CNT_W-1:0]  drop_count,
  output logic              overflow,
  output logic              done
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef struct packed {
    logic [CNT_W-1:0]  inum;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] maddr;
    logic [DATA_W-1:0] mdata;
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              halt;
    logic [2:0]        wreg;
  } rec_t;

  typedef enum logic [1:0] {
    RUN,
    HALTED,
    DONE
  } state_t;

  rec_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  state_t        state;

  rec_t head;
  rec_t new_rec;
  logic full;
  logic pop;
  logic store_ev;
  logic try_push;
  logic push;
  logic drop;
  logic accept;

  // The output always reflects the registered head entry. Because storage is
  // cleared on reset, all out_* fields read 0 until the first push.
  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);

  assign out_inum     = head.inum;
  assign out_pc       = head.pc;
  assign out_wdata    = head.wdata;
  assign out_maddr    = head.maddr;
  assign out_mdata    = head.mdata;
  assign out_regwrite = head.regwrite;
  assign out_memread  = head.memread;
  assign out_memwrite = head.memwrite;
  assign out_halt     = head.halt;
  assign out_wreg     = head.wreg;

  always_comb begin
`ifdef RETIRE_TRACE_FILTER_EN
    store_ev = ev_regwrite | ev_memwrite | ev_halt;
`else
    store_ev = 1'b1;
`endif
    full     = (count == FULL_CNT);
    pop      = out_valid && out_ready;
    try_push = ev_valid && (state == RUN) && store_ev;
    // A full FIFO can still take the event when the head leaves in this cycle.
    push     = try_push && (!full || pop);
    drop     = try_push && full && !pop;
    // Filtered events count as retired even though they are not stored.
    accept   = push || (ev_valid && (state == RUN) && !store_ev);

    new_rec          = '0;
    new_rec.inum     = inst_count;
    new_rec.pc       = ev_pc;
    new_rec.wdata    = ev_wdata;
    new_rec.maddr    = ev_maddr;
    new_rec.mdata    = ev_mdata;
    new_rec.regwrite = ev_regwrite;
    new_rec.memread  = ev_memread;
    new_rec.memwrite = ev_memwrite;
    new_rec.halt     = ev_halt;
    new_rec.wreg     = ev_wreg;
  end

  // FIFO storage, pointers, and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      inst_count <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_rec;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (accept) begin
        inst_count <= inst_count + CNT_W'(1);
      end
      if (drop) begin
        drop_count <= drop_count + CNT_W'(1);
        overflow   <= 1'b1;
      end
    end
  end

  // Run/halt state machine. Only one halt record can ever be stored, because
  // pushes stop once it is in. So a head halt record seen in HALTED is the
  // record that ends the run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      done  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (push && ev_halt) begin
            state <= HALTED;
          end
        end
        HALTED: begin
          if (pop && head.halt) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        default: begin
          state <= RUN;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
